pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, PC loaded at reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0040_0004, exception entry address (used only with PC_FETCH_EXC_EN).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port fetch_req  out  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  out  32  fetch address, always equal to pc.
REQ-007 SHALL have port imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata  in  32  instruction word.
REQ-009 SHALL have port ir  out  32  latched instruction register.
REQ-010 SHALL have port ir_valid  out  1  ir holds the current instruction; controller may execute.
REQ-011 SHALL have port pc_we  in  1  controller strobe: retire instruction, update PC.
REQ-012 SHALL have port pc_sel  in  3  next-PC source: 0 seq, 1 branch, 2 jump, 3 jr, 4 exc, 5 eret, 6-7 reserved.
REQ-013 SHALL have port br_off  in  32  sign-extended word offset already shifted left by 2.
REQ-014 SHALL have port jr_addr  in  32  register target for jr/jalr.
REQ-015 SHALL have ports pc out 32 (current PC) and pc_plus4 out 32 (pc + 4, for link writeback).

Function
REQ-016 SHALL implement FSM with states FETCH and EXEC; reset state FETCH.
REQ-017 In FETCH SHALL drive fetch_req=1, ir_valid=0; on imem_ack SHALL latch imem_rdata into ir and enter EXEC next cycle.
REQ-018 In EXEC SHALL drive fetch_req=0, ir_valid=1, hold ir and pc until pc_we.
REQ-019 On pc_we in EXEC SHALL load pc with next-PC per pc_sel on the same edge and return to FETCH (ir_valid=0 next cycle); minimum instruction period 2 cycles (ack in first FETCH cycle).
REQ-020 Next-PC: seq = pc+4; branch = pc+4+br_off; jump = {pc_plus4[31:28], ir[25:0], 2'b00}; jr = {jr_addr[31:2], 2'b00}.
REQ-021 All additions SHALL be 32-bit modulo, carry discarded (pc 32'hFFFF_FFFC seq -> 32'h0000_0000).
REQ-022 pc[1:0] SHALL always be 2'b00.
REQ-023 imem_ack in EXEC and pc_we in FETCH SHALL be ignored; pc_we and imem_ack together in the same cycle act per current state only.
REQ-024 pc_sel 6-7 SHALL behave as seq.
REQ-025 pc_plus4 SHALL be combinational from pc.

Reset
REQ-026 While rst_n=0: pc=RESET_PC, ir=0, state=FETCH, fetch_req=0, ir_valid=0, epc=0 (if present).
REQ-027 fetch_req SHALL first assert on the first clock edge after rst_n deasserts; reset asserted mid-fetch or mid-exec SHALL abort immediately with no PC update.

Configuration
REQ-028 Macro PC_FETCH_EXC_EN: when defined, 32-bit epc register exists; exc: epc<=pc, pc<=EXC_VEC; eret: pc<=epc+4.
REQ-029 Without PC_FETCH_EXC_EN: no epc storage, pc_sel 4 and 5 behave as seq, EXC_VEC unused.

Structure
REQ-030 Package cpu_pkg SHALL hold pc_sel encodings (PC_SEQ..PC_ERET) and default RESET_PC/EXC_VEC constants.
REQ-031 One sub-module npc_mux (combinational next-PC selection, REQ-020/021/028) SHALL be instantiated; FSM and registers stay in pc_fetch_unit.

Verification
REQ-032 Reset release, ack on first FETCH cycle with 32'h2008_0005 -> imem_addr 32'h0040_0000, ir=32'h2008_0005, ir_valid=1 one cycle later.
REQ-033 EXEC, pc=32'h0040_0010, pc_sel=1, br_off=32'hFFFF_FFF8 -> pc=32'h0040_000C.
REQ-034 EXEC, pc=32'h0040_0020, ir=32'h0810_0040, pc_sel=2 -> pc=32'h0040_0100; pc_sel=3, jr_addr=32'h0040_0203 -> pc=32'h0040_0200.
REQ-035 Memory withholds ack 5 cycles -> fetch_req held 5 cycles, pc stable; pc_we pulsed during FETCH -> no effect.
REQ-036 PC_FETCH_EXC_EN: pc=32'h0040_0030, pc_sel=4 -> pc=32'h0040_0004, epc=32'h0040_0030; later pc_sel=5 -> pc=32'h0040_0034; without macro same stimulus -> pc+4.
REQ-037 rst_n pulsed low in EXEC at pc=32'h0040_0050 -> pc=32'h0040_0000, ir_valid=0 immediately; seq at 32'hFFFF_FFFC -> 32'h0000_0000.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Next-PC source encodings, fetch FSM states and default vectors
//               shared by the PC / instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam logic [31:0] c_reset_pc_default = 32'h0040_0000;
   localparam logic [31:0] c_exc_vec_default  = 32'h0040_0004;

   typedef enum logic [2:0] {
      PC_SEQ    = 3'd0,
      PC_BRANCH = 3'd1,
      PC_JUMP   = 3'd2,
      PC_JR     = 3'd3,
      PC_EXC    = 3'd4,
      PC_ERET   = 3'd5
   } pc_sel_e;

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory request/response bundle between the fetch
//               unit (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
   logic        fetch_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output fetch_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  fetch_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_npc_mux.sv
`default_nettype none
// ============================================================================
// Module      : npc_mux
// Description : Combinational next-PC selection. Exception entry / return
//               paths exist only when PC_FETCH_EXC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_mux
   import cpu_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = c_exc_vec_default
) (
   input  logic [2:0]  i_pc_sel,
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_br_off,
   input  logic [25:0] i_jump_index,
   input  logic [31:0] i_jr_addr,
`ifdef PC_FETCH_EXC_EN
   input  logic [31:0] i_epc,
`endif
   output logic [31:0] o_npc
);

   logic [31:0] w_npc_raw;

   // Reserved encodings (and exc/eret when exceptions are compiled out) fall to seq
   always_comb begin
      w_npc_raw = i_pc_plus4;
      case (i_pc_sel)
         PC_BRANCH: w_npc_raw = i_pc_plus4 + i_br_off;
         PC_JUMP:   w_npc_raw = {i_pc_plus4[31:28], i_jump_index, 2'b00};
         PC_JR:     w_npc_raw = i_jr_addr;
`ifdef PC_FETCH_EXC_EN
         PC_EXC:    w_npc_raw = EXC_VEC;
         PC_ERET:   w_npc_raw = i_epc + 32'd4;
`endif
         default:   w_npc_raw = i_pc_plus4;
      endcase
   end

   // Forcing the low bits keeps pc word-aligned whatever the source
   assign o_npc = word_align(w_npc_raw);

`ifndef PC_FETCH_EXC_EN
   logic w_unused_exc_vec;
   assign w_unused_exc_vec = |EXC_VEC;
`endif

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC register, instruction register and FETCH/EXEC sequencer.
//               Define PC_FETCH_EXC_EN to add the epc register and exc/eret.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_reset_pc_default,
   parameter logic [31:0] EXC_VEC  = c_exc_vec_default
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pc_fetch_unit_if.master        imem,
   output logic [31:0]            ir,
   output logic                   ir_valid,
   input  logic                   pc_we,
   input  logic [2:0]             pc_sel,
   input  logic [31:0]            br_off,
   input  logic [31:0]            jr_addr,
   output logic [31:0]            pc,
   output logic [31:0]            pc_plus4
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic         r_run;
   logic [31:0]  r_pc;
   logic [31:0]  r_ir;
   logic [31:0]  w_npc;
   logic         w_fetch_req;
   logic         w_ir_valid;
   logic         w_ir_load;
   logic         w_pc_load;

   // r_run holds fetch_req low for the first cycle after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fetch_req = 1'b0;
      w_ir_valid  = 1'b0;
      w_ir_load   = 1'b0;
      w_pc_load   = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_fetch_req = r_run;
            if (r_run && imem.imem_ack) begin
               w_ir_load   = 1'b1;
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            w_ir_valid = 1'b1;
            if (pc_we) begin
               w_pc_load   = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= word_align(RESET_PC);
         r_ir <= '0;
      end else begin
         if (w_pc_load) r_pc <= w_npc;
         if (w_ir_load) r_ir <= imem.imem_rdata;
      end
   end

`ifdef PC_FETCH_EXC_EN
   logic [31:0] r_epc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_epc <= '0;
      else if (w_pc_load && (pc_sel == PC_EXC))
         r_epc <= r_pc;
   end
`endif

   npc_mux #(
      .EXC_VEC      (EXC_VEC)
   ) u_npc_mux (
      .i_pc_sel     (pc_sel),
      .i_pc_plus4   (pc_plus4),
      .i_br_off     (br_off),
      .i_jump_index (r_ir[25:0]),
      .i_jr_addr    (jr_addr),
`ifdef PC_FETCH_EXC_EN
      .i_epc        (r_epc),
`endif
      .o_npc        (w_npc)
   );

   assign pc             = r_pc;
   assign pc_plus4       = r_pc + 32'd4;
   assign ir             = r_ir;
   assign ir_valid       = w_ir_valid;
   assign imem.fetch_req = w_fetch_req;
   assign imem.imem_addr = r_pc;

endmodule
`default_nettype wire
